// File: rtl/up_gpio_regs.sv
// up_gpio_regs -- GPIO register core sitting behind the wishbone-to-up bridge.
//
// Consumes single-cycle up_* read/write strobes and owns the GPIO state:
// output data, tristate control, and optional edge-interrupt enable/status.
// Pin inputs are synchronised and compared against their previous value to
// flag both rising and falling edges.
//
// Register map (word address):
//   0 DATA_IN   RO     synchronised gpio_io_i
//   1 DATA_OUT  RW     drives gpio_io_o
//   2 TRI       RW     drives gpio_io_t (1 = high-Z / input)
//   3 IRQ_EN    RW     per-bit edge interrupt enable   (reads 0 if IRQ_ENABLE=0)
//   4 IRQ_STAT  R/W1C  per-bit edge flags              (reads 0 if IRQ_ENABLE=0)
//   other       reads 0, writes ignored; both acknowledged normally
//
// Ports:
//   clk, rstn                     clock, synchronous active-low reset
//   up_rreq/up_raddr              read strobe and word address
//   up_rack/up_rdata              read acknowledge and data (0 when not acking)
//   up_wreq/up_waddr/up_wdata     write strobe, word address and data
//   up_wack                       write acknowledge
//   irq                           registered level interrupt |(stat & en)
//   gpio_io_i                     asynchronous pin inputs
//   gpio_io_o / gpio_io_t         pin output data / tristate control

module up_gpio_regs #(
  parameter int                    ADDRESS_WIDTH = 14,
  parameter int                    BUS_WIDTH     = 4,
  parameter int                    GPIO_WIDTH    = 32,
  parameter int                    IRQ_ENABLE    = 0,
  parameter logic [GPIO_WIDTH-1:0] DEFAULT_TRI   = '1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     up_rreq,
  input  logic [ADDRESS_WIDTH-1:0] up_raddr,
  output logic                     up_rack,
  output logic [BUS_WIDTH*8-1:0]   up_rdata,
  input  logic                     up_wreq,
  input  logic [ADDRESS_WIDTH-1:0] up_waddr,
  input  logic [BUS_WIDTH*8-1:0]   up_wdata,
  output logic                     up_wack,
  output logic                     irq,
  input  logic [GPIO_WIDTH-1:0]    gpio_io_i,
  output logic [GPIO_WIDTH-1:0]    gpio_io_o,
  output logic [GPIO_WIDTH-1:0]    gpio_io_t
);

  localparam int DW     = BUS_WIDTH * 8;
  localparam bit IRQ_ON = (IRQ_ENABLE != 0);

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_DATA_IN  = ADDRESS_WIDTH'(0);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_DATA_OUT = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_TRI      = ADDRESS_WIDTH'(2);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_IRQ_EN   = ADDRESS_WIDTH'(3);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_IRQ_STAT = ADDRESS_WIDTH'(4);

  // Zero-extend a GPIO-wide value onto the bus; bits above GPIO_WIDTH read 0.
  function automatic logic [DW-1:0] to_bus(input logic [GPIO_WIDTH-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    r[GPIO_WIDTH-1:0] = v;
    return r;
  endfunction

  logic [GPIO_WIDTH-1:0] gpio_sync_p0;
  logic [GPIO_WIDTH-1:0] gpio_sync_p1;
  logic [GPIO_WIDTH-1:0] gpio_prev_p2;
  logic [1:0]            settle_cnt;
  logic [GPIO_WIDTH-1:0] irq_en;
  logic [GPIO_WIDTH-1:0] irq_stat;

  logic [GPIO_WIDTH-1:0] wdata_g;
  logic                  wr_out;
  logic                  wr_tri;
  logic                  wr_en;
  logic                  wr_stat;
  logic [GPIO_WIDTH-1:0] edge_det;
  logic [GPIO_WIDTH-1:0] stat_next;
  logic [DW-1:0]         rd_mux;

  assign wdata_g = up_wdata[GPIO_WIDTH-1:0];
  assign wr_out  = up_wreq && (up_waddr == ADDR_DATA_OUT);
  assign wr_tri  = up_wreq && (up_waddr == ADDR_TRI);
  assign wr_en   = up_wreq && (up_waddr == ADDR_IRQ_EN);
  assign wr_stat = up_wreq && (up_waddr == ADDR_IRQ_STAT);

  // Edges are masked until the synchroniser and prev flop have all been
  // loaded from the pins after reset, otherwise the 0 -> pin fill would
  // look like an edge on every high input.
  always_comb begin
    edge_det = '0;
    if (settle_cnt == 2'd3)
      edge_det = gpio_sync_p1 ^ gpio_prev_p2;
  end

  // A new edge wins over a W1C on the same bit in the same cycle.
  always_comb begin
    stat_next = '0;
    if (IRQ_ON)
      stat_next = (irq_stat & ~(wr_stat ? wdata_g : '0)) | edge_det;
  end

  // Read mux sees register values before this cycle's write lands, so a
  // same-cycle read of a written address returns the old value.
  always_comb begin
    rd_mux = '0;
    case (up_raddr)
      ADDR_DATA_IN:  rd_mux = to_bus(gpio_sync_p1);
      ADDR_DATA_OUT: rd_mux = to_bus(gpio_io_o);
      ADDR_TRI:      rd_mux = to_bus(gpio_io_t);
      ADDR_IRQ_EN:   rd_mux = to_bus(irq_en);
      ADDR_IRQ_STAT: rd_mux = to_bus(irq_stat);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      gpio_sync_p0 <= '0;
      gpio_sync_p1 <= '0;
      gpio_prev_p2 <= '0;
      settle_cnt   <= 2'd0;
      up_rack      <= 1'b0;
      up_rdata     <= '0;
      up_wack      <= 1'b0;
      gpio_io_o    <= '0;
      gpio_io_t    <= DEFAULT_TRI;
      irq_en       <= '0;
      irq_stat     <= '0;
      irq          <= 1'b0;
    end else begin
      // p0 -> p1: two-flop synchroniser; p2: previous value for edge compare
      gpio_sync_p0 <= gpio_io_i;
      gpio_sync_p1 <= gpio_sync_p0;
      gpio_prev_p2 <= gpio_sync_p1;

      if (settle_cnt != 2'd3)
        settle_cnt <= settle_cnt + 2'd1;

      up_rack  <= up_rreq;
      up_rdata <= up_rreq ? rd_mux : '0;
      up_wack  <= up_wreq;

      if (wr_out)
        gpio_io_o <= wdata_g;
      if (wr_tri)
        gpio_io_t <= wdata_g;
      if (wr_en && IRQ_ON)
        irq_en <= wdata_g;

      irq_stat <= stat_next;
      irq      <= IRQ_ON && (|(irq_stat & irq_en));
    end
  end

endmodule

// File: tb/tb_up_gpio_regs.sv
// tb_up_gpio_regs -- directed bench for up_gpio_regs.
// u0: 32 GPIO lines with interrupt logic; u1: 8 GPIO lines without it.
// Read expectations are queued when a read is issued and popped when the
// acknowledge arrives.

module tb_up_gpio_regs;

  logic        tb_data_clk = 1'b0;
  logic        rstn;

  logic        rreq0, wreq0, rack0, wack0, irq0;
  logic [13:0] raddr0, waddr0;
  logic [31:0] rdata0, wdata0;
  logic [31:0] gi0, go0, gt0;

  logic        rreq1, wreq1, rack1, wack1, irq1;
  logic [13:0] raddr1, waddr1;
  logic [31:0] rdata1, wdata1;
  logic [7:0]  gi1, go1, gt1;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 tb_data_clk = ~tb_data_clk;

  up_gpio_regs #(
    .ADDRESS_WIDTH(14), .BUS_WIDTH(4), .GPIO_WIDTH(32), .IRQ_ENABLE(1),
    .DEFAULT_TRI(32'hFFFF_FFFF)
  ) u0 (
    .clk(tb_data_clk), .rstn(rstn),
    .up_rreq(rreq0), .up_raddr(raddr0), .up_rack(rack0), .up_rdata(rdata0),
    .up_wreq(wreq0), .up_waddr(waddr0), .up_wdata(wdata0), .up_wack(wack0),
    .irq(irq0), .gpio_io_i(gi0), .gpio_io_o(go0), .gpio_io_t(gt0)
  );

  up_gpio_regs #(
    .ADDRESS_WIDTH(14), .BUS_WIDTH(4), .GPIO_WIDTH(8), .IRQ_ENABLE(0),
    .DEFAULT_TRI(8'hFF)
  ) u1 (
    .clk(tb_data_clk), .rstn(rstn),
    .up_rreq(rreq1), .up_raddr(raddr1), .up_rack(rack1), .up_rdata(rdata1),
    .up_wreq(wreq1), .up_waddr(waddr1), .up_wdata(wdata1), .up_wack(wack1),
    .irq(irq1), .gpio_io_i(gi1), .gpio_io_o(go1), .gpio_io_t(gt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_data_clk);
    #1;
  endtask

  // One bus cycle on instance sel: optional read and/or write in the same cycle.
  task automatic bus_xfer(input int sel, input bit do_r, input logic [13:0] ra,
                          input bit do_w, input logic [13:0] wa, input logic [31:0] wd,
                          input logic [31:0] exp, input string tag);
    logic        rk, wk;
    logic [31:0] rd, e;
    string       t;
    if (do_r) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    if (sel == 0) begin
      rreq0 = do_r; raddr0 = ra; wreq0 = do_w; waddr0 = wa; wdata0 = wd;
    end else begin
      rreq1 = do_r; raddr1 = ra; wreq1 = do_w; waddr1 = wa; wdata1 = wd;
    end
    step();
    rreq0 = 1'b0; wreq0 = 1'b0; rreq1 = 1'b0; wreq1 = 1'b0;
    rk = (sel == 0) ? rack0 : rack1;
    wk = (sel == 0) ? wack0 : wack1;
    rd = (sel == 0) ? rdata0 : rdata1;
    if (do_w) chk({tag, "_wack"}, 32'(wk), 32'd1);
    if (do_r) begin
      chk({tag, "_rack"}, 32'(rk), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (rk) chk(t, rd, e);
      end
    end
  endtask

  task automatic rd(input int sel, input logic [13:0] a, input logic [31:0] exp, input string tag);
    bus_xfer(sel, 1'b1, a, 1'b0, 14'd0, 32'd0, exp, tag);
  endtask

  task automatic wr(input int sel, input logic [13:0] a, input logic [31:0] d, input string tag);
    bus_xfer(sel, 1'b0, 14'd0, 1'b1, a, d, 32'd0, tag);
  endtask

  initial begin
    rstn = 1'b0;
    rreq0 = 0; raddr0 = 0; wreq0 = 0; waddr0 = 0; wdata0 = 0;
    rreq1 = 0; raddr1 = 0; wreq1 = 0; waddr1 = 0; wdata1 = 0;
    gi0 = 32'hFFFF_FFFF;
    gi1 = 8'hA5;

    // Reset state
    repeat (3) step();
    chk("rst_rack", 32'(rack0), 32'd0);
    chk("rst_wack", 32'(wack0), 32'd0);
    chk("rst_rdata", rdata0, 32'd0);
    chk("rst_irq", 32'(irq0), 32'd0);
    chk("rst_gpio_o", go0, 32'd0);
    chk("rst_gpio_t", gt0, 32'hFFFF_FFFF);
    chk("rst_gpio_t_u1", 32'(gt1), 32'h0000_00FF);

    rstn = 1'b1;
    repeat (10) step();
    rd(0, 14'd4, 32'd0, "post_rst_stat");
    rd(0, 14'd0, 32'hFFFF_FFFF, "post_rst_data_in");
    chk("post_rst_gpio_t", gt0, 32'hFFFF_FFFF);
    chk("post_rst_irq", 32'(irq0), 32'd0);

    // Output data register, single-cycle acks
    wr(0, 14'd1, 32'hAAAA_0000, "wr_out");
    chk("gpio_o_aaaa", go0, 32'hAAAA_0000);
    step();
    chk("wack_one_cycle", 32'(wack0), 32'd0);
    rd(0, 14'd1, 32'hAAAA_0000, "rd_out");
    step();
    chk("rack_one_cycle", 32'(rack0), 32'd0);
    chk("rdata_idle_zero", rdata0, 32'd0);

    wr(0, 14'd2, 32'h0000_FFFF, "wr_tri");
    chk("gpio_t_ffff", gt0, 32'h0000_FFFF);
    rd(0, 14'd2, 32'h0000_FFFF, "rd_tri");

    // All pins fall: flags set even with IRQ_EN=0, irq stays low
    gi0 = 32'h0;
    repeat (6) step();
    chk("irq_masked", 32'(irq0), 32'd0);
    rd(0, 14'd4, 32'hFFFF_FFFF, "stat_all_fall");
    rd(0, 14'd0, 32'h0, "data_in_low");
    wr(0, 14'd4, 32'hFFFF_FFFF, "w1c_all");
    rd(0, 14'd4, 32'h0, "stat_cleared");

    // Enable bit 0, rising edge -> irq four clocks later
    wr(0, 14'd3, 32'h1, "wr_en");
    rd(0, 14'd3, 32'h1, "rd_en");
    gi0 = 32'h1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("irq_lat_%0d", k), 32'(irq0), (k == 4) ? 32'd1 : 32'd0);
    end
    rd(0, 14'd4, 32'h1, "stat_rise");

    // W1C: irq drops two clocks after the strobe
    wr(0, 14'd4, 32'h1, "w1c_b0");
    chk("irq_after_w1c_1", 32'(irq0), 32'd1);
    step();
    chk("irq_after_w1c_2", 32'(irq0), 32'd0);

    // W1C colliding with a new edge on the same bit: set wins
    gi0 = 32'h0;
    repeat (6) step();
    chk("irq_fall", 32'(irq0), 32'd1);
    gi0 = 32'h1;
    step();
    step();
    wr(0, 14'd4, 32'h1, "w1c_collide");
    chk("irq_collide_1", 32'(irq0), 32'd1);
    step();
    chk("irq_collide_2", 32'(irq0), 32'd1);
    rd(0, 14'd4, 32'h1, "stat_collide");
    wr(0, 14'd4, 32'h1, "w1c_final");
    rd(0, 14'd4, 32'h0, "stat_final");
    chk("irq_final", 32'(irq0), 32'd0);

    // Unmapped read and write in the same cycle
    bus_xfer(0, 1'b1, 14'd7, 1'b1, 14'd9, 32'hFFFF_FFFF, 32'd0, "unmapped");
    rd(0, 14'd1, 32'hAAAA_0000, "unmapped_out");
    rd(0, 14'd2, 32'h0000_FFFF, "unmapped_tri");
    rd(0, 14'd3, 32'h1, "unmapped_en");
    rd(0, 14'd4, 32'h0, "unmapped_stat");

    // Same-cycle read of the written address returns the old value
    bus_xfer(0, 1'b1, 14'd1, 1'b1, 14'd1, 32'h1234_5678, 32'hAAAA_0000, "rw_same");
    chk("rw_same_gpio_o", go0, 32'h1234_5678);
    rd(0, 14'd1, 32'h1234_5678, "rw_same_new");

    // Narrow instance without interrupt logic
    rd(1, 14'd0, 32'h0000_00A5, "u1_data_in");
    wr(1, 14'd1, 32'hFFFF_FFFF, "u1_wr_out");
    chk("u1_gpio_o", 32'(go1), 32'h0000_00FF);
    rd(1, 14'd1, 32'h0000_00FF, "u1_rd_out");
    wr(1, 14'd3, 32'hFFFF_FFFF, "u1_wr_en");
    rd(1, 14'd3, 32'h0, "u1_rd_en");
    gi1 = 8'h5A;
    repeat (6) step();
    chk("u1_irq", 32'(irq1), 32'd0);
    rd(1, 14'd4, 32'h0, "u1_rd_stat");

    // Requests in the reset cycle are not acknowledged
    rstn = 1'b0;
    rreq0 = 1'b1; raddr0 = 14'd1;
    wreq0 = 1'b1; waddr0 = 14'd1; wdata0 = 32'h5555_5555;
    step();
    rreq0 = 1'b0; wreq0 = 1'b0;
    chk("rstmid_wack", 32'(wack0), 32'd0);
    chk("rstmid_rack", 32'(rack0), 32'd0);
    chk("rstmid_rdata", rdata0, 32'd0);
    chk("rstmid_gpio_o", go0, 32'd0);
    chk("rstmid_gpio_t", gt0, 32'hFFFF_FFFF);
    chk("rstmid_irq", 32'(irq0), 32'd0);
    rstn = 1'b1;
    repeat (5) step();
    rd(0, 14'd1, 32'h0, "rstmid_out");
    rd(0, 14'd2, 32'hFFFF_FFFF, "rstmid_tri");
    rd(0, 14'd3, 32'h0, "rstmid_en");
    rd(0, 14'd4, 32'h0, "rstmid_stat");
    rd(0, 14'd0, 32'h1, "rstmid_data_in");

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
